// File: rtl/rv32im_dmem_ctrl.sv
// Data-memory bus controller between the rv32im LSU and a valid/ready bus.
// Issues one request per LSU access, steers store lanes, stalls until response or timeout.
module rv32im_dmem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        wr_mask_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              fault_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [3:0]        req_be_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_rdata_i,
    input  logic              rsp_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [7:0]          cnt_r;
    logic                timeout_s;
    logic                fault_r;
    logic                stall_s;
    logic                req_we_r;
    logic [ADDR_W-1:0]   req_addr_r;
    logic [3:0]          req_be_r;
    logic [DATA_W-1:0]   req_wdata_r;
    logic [DATA_W-1:0]   rdata_r;

    // Byte stores replicate the low byte, halfword stores the low half, others pass through.
    function automatic logic [DATA_W-1:0] steer_wdata(input logic [3:0] mask,
                                                      input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] res;
        case (mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: res = {4{wdata[7:0]}};
            4'b0011, 4'b1100:                   res = {2{wdata[15:0]}};
            default:                            res = wdata;
        endcase
        return res;
    endfunction

    assign timeout_s = (cnt_r == TIMEOUT_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; in REQ the timeout beats a handshake, in WAIT a response beats the timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_i) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (timeout_s) begin
                    state_next_s = ST_DONE;
                end else if (req_ready_i) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rsp_valid_i || timeout_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Request registers, captured once when an access is accepted in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_we_r    <= 1'b0;
            req_addr_r  <= '0;
            req_be_r    <= 4'b0000;
            req_wdata_r <= '0;
        end else if (state_r == ST_IDLE && enable_i) begin
            req_we_r    <= (wr_mask_i != 4'b0000);
            req_addr_r  <= addr_i;
            req_be_r    <= (wr_mask_i == 4'b0000) ? 4'b1111 : wr_mask_i;
            req_wdata_r <= steer_wdata(wr_mask_i, wdata_i);
        end else begin
            req_we_r    <= req_we_r;
            req_addr_r  <= req_addr_r;
            req_be_r    <= req_be_r;
            req_wdata_r <= req_wdata_r;
        end
    end

    // Cycle counter covering REQ and WAIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= 8'd0;
        end else if (state_r == ST_IDLE && enable_i) begin
            cnt_r <= 8'd0;
        end else if (state_r == ST_REQ || state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Fault flag and read word; a faulted read returns zero, writes never touch rdata.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_r <= 1'b0;
            rdata_r <= '0;
        end else if (state_r == ST_IDLE && enable_i) begin
            fault_r <= 1'b0;
            rdata_r <= rdata_r;
        end else if (state_r == ST_WAIT && rsp_valid_i) begin
            fault_r <= rsp_err_i;
            if (!req_we_r) begin
                rdata_r <= rsp_err_i ? '0 : rsp_rdata_i;
            end else begin
                rdata_r <= rdata_r;
            end
        end else if ((state_r == ST_REQ || state_r == ST_WAIT) && timeout_s) begin
            fault_r <= 1'b1;
            if (!req_we_r) begin
                rdata_r <= '0;
            end else begin
                rdata_r <= rdata_r;
            end
        end else begin
            fault_r <= fault_r;
            rdata_r <= rdata_r;
        end
    end

    // Pipeline stall: follows enable_i while idle so the LSU freezes in the accept cycle.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = enable_i;
            ST_REQ:  stall_s = 1'b1;
            ST_WAIT: stall_s = 1'b1;
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    assign stall_o     = stall_s;
    assign done_o      = (state_r == ST_DONE);
    assign fault_o     = (state_r == ST_DONE) && fault_r;
    assign req_valid_o = (state_r == ST_REQ);
    assign req_we_o    = req_we_r;
    assign req_addr_o  = req_addr_r;
    assign req_be_o    = req_be_r;
    assign req_wdata_o = req_wdata_r;
    assign rdata_o     = rdata_r;

endmodule

// File: tb/tb_rv32im_dmem_ctrl.sv
// Self-checking bench for rv32im_dmem_ctrl: directed and random accesses against a
// transaction-level model; a second instance with TIMEOUT=4 covers the abort paths.
module tb_rv32im_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        en_t = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  mask = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic        rsp_err = 1'b0;
    logic [31:0] rsp_rdata = 32'd0;

    logic [31:0] rdata, req_addr, req_wdata;
    logic        stall, done, fault, req_valid, req_we;
    logic [3:0]  req_be;
    logic [31:0] t_rdata, t_req_addr, t_req_wdata;
    logic        t_stall, t_done, t_fault, t_req_valid, t_req_we;
    logic [3:0]  t_req_be;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    rv32im_dmem_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .addr_i(addr), .wr_mask_i(mask),
        .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall), .done_o(done), .fault_o(fault),
        .req_valid_o(req_valid), .req_ready_i(req_ready), .req_we_o(req_we),
        .req_addr_o(req_addr), .req_be_o(req_be), .req_wdata_o(req_wdata),
        .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata), .rsp_err_i(rsp_err)
    );

    rv32im_dmem_ctrl #(.TIMEOUT(4)) dut_t (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_t), .addr_i(addr), .wr_mask_i(mask),
        .wdata_i(wdata), .rdata_o(t_rdata), .stall_o(t_stall), .done_o(t_done), .fault_o(t_fault),
        .req_valid_o(t_req_valid), .req_ready_i(req_ready), .req_we_o(t_req_we),
        .req_addr_o(t_req_addr), .req_be_o(t_req_be), .req_wdata_o(t_req_wdata),
        .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata), .rsp_err_i(rsp_err)
    );

    // One complete access on the main instance: rdly idle-ready REQ cycles, vdly silent WAIT cycles.
    task automatic run_access(input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd,
                              input int rdly, input int vdly, input bit err,
                              input logic [31:0] rd, input bit keep_en);
        logic       e_we;
        logic [3:0] e_be;
        logic [31:0] e_wd;
        e_we = (m != 4'd0);
        e_be = e_we ? m : 4'hF;
        if ($countones(m) == 1)             e_wd = {24'd0, wd[7:0]} * 32'h01010101;
        else if (m == 4'b0011 || m == 4'b1100) e_wd = {16'd0, wd[15:0]} * 32'h00010001;
        else                                e_wd = wd;

        @(negedge clk);
        n_checks++;
        if ({done, fault, req_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle: done/fault/valid=%b required 000", {done, fault, req_valid});
        end
        enable = 1'b1; addr = a; mask = m; wdata = wd;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_stall: stall=%b required 1", stall);
        end

        for (int c = 0; c <= rdly; c++) begin
            @(negedge clk);
            n_checks++;
            if ({req_valid, stall, done, req_we, req_be, req_addr, req_wdata, rdata} !==
                {1'b1, 1'b1, 1'b0, e_we, e_be, a, e_wd, exp_rdata}) begin
                n_fail++;
                $display("FAIL req c=%0d: v=%b st=%b dn=%b we=%b be=%b a=%h wd=%h rd=%h required v=1 st=1 dn=0 we=%b be=%b a=%h wd=%h rd=%h",
                         c, req_valid, stall, done, req_we, req_be, req_addr, req_wdata, rdata,
                         e_we, e_be, a, e_wd, exp_rdata);
            end
            req_ready = (c == rdly);
            rsp_valid = (c < rdly) ? 1'($urandom) : 1'b0;
            rsp_rdata = $urandom;
            rsp_err   = 1'($urandom);
        end

        for (int c = 0; c <= vdly; c++) begin
            @(negedge clk);
            n_checks++;
            if ({req_valid, stall, done, rdata} !== {1'b0, 1'b1, 1'b0, exp_rdata}) begin
                n_fail++;
                $display("FAIL wait c=%0d: v=%b st=%b dn=%b rd=%h required v=0 st=1 dn=0 rd=%h",
                         c, req_valid, stall, done, rdata, exp_rdata);
            end
            req_ready = 1'($urandom);
            rsp_valid = (c == vdly);
            rsp_rdata = (c == vdly) ? rd : $urandom;
            rsp_err   = (c == vdly) ? err : 1'($urandom);
        end
        if (!e_we) exp_rdata = err ? 32'd0 : rd;

        @(negedge clk);
        n_checks++;
        if ({done, fault, stall, req_valid, rdata} !== {1'b1, err, 1'b0, 1'b0, exp_rdata}) begin
            n_fail++;
            $display("FAIL done: dn=%b flt=%b st=%b v=%b rd=%h required dn=1 flt=%b st=0 v=0 rd=%h",
                     done, fault, stall, req_valid, rdata, err, exp_rdata);
        end
        rsp_valid = 1'b0; rsp_err = 1'b0; req_ready = 1'b0;
        if (!keep_en) enable = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({rdata, stall, done, fault, req_valid, req_we, req_addr, req_be, req_wdata} !== 106'd0) begin
            n_fail++;
            $display("FAIL reset_main: outputs=%h required 0",
                     {rdata, stall, done, fault, req_valid, req_we, req_addr, req_be, req_wdata});
        end
        n_checks++;
        if ({t_rdata, t_stall, t_done, t_fault, t_req_valid, t_req_we, t_req_addr, t_req_be, t_req_wdata} !== 106'd0) begin
            n_fail++;
            $display("FAIL reset_t: outputs=%h required 0",
                     {t_rdata, t_stall, t_done, t_fault, t_req_valid, t_req_we, t_req_addr, t_req_be, t_req_wdata});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read_zero_wait();
        run_access(32'h40, 4'b0000, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_sb_steering();
        run_access(32'h44, 4'b0100, 32'h000000A5, 0, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_sh_backpressure();
        run_access(32'h48, 4'b1100, 32'h00001234, 4, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_bus_error();
        run_access(32'h4C, 4'b0000, 32'h0, 0, 0, 1'b1, 32'h00000055, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_access(32'h100, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h11223344, 1'b1);
        run_access(32'h104, 4'b0011, 32'hFFFFBEEF, 1, 1, 1'b0, 32'h0, 1'b1);
        run_access(32'h108, 4'b0000, 32'h0, 0, 2, 1'b0, 32'h55667788, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_access($urandom, 4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                       ($urandom_range(0, 3) == 0), $urandom, (i != 23) && 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_wait();
        run_access(32'h200, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h13579BDF, 1'b0);
        @(negedge clk);
        enable = 1'b1; addr = 32'h204; mask = 4'b0000;
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        n_checks++;
        if ({stall, rdata} !== {1'b1, 32'h13579BDF}) begin
            n_fail++;
            $display("FAIL pre_reset: st=%b rd=%h required st=1 rd=13579bdf", stall, rdata);
        end
        rst_n = 1'b0; enable = 1'b0;
        #1;
        n_checks++;
        if ({req_valid, stall, done, rdata} !== 35'd0) begin
            n_fail++;
            $display("FAIL mid_reset: v=%b st=%b dn=%b rd=%h required all 0", req_valid, stall, done, rdata);
        end
        exp_rdata = 32'd0;
        for (int c = 0; c < 2; c++) begin
            rsp_valid = 1'b1; rsp_rdata = 32'hA5A5A5A5;
            @(negedge clk);
            n_checks++;
            if ({done, req_valid, rdata} !== 34'd0) begin
                n_fail++;
                $display("FAIL in_reset c=%0d: dn=%b v=%b rd=%h required 0", c, done, req_valid, rdata);
            end
        end
        rsp_valid = 1'b0;
        rst_n = 1'b1;
        run_access(32'h208, 4'b0000, 32'h0, 1, 1, 1'b0, 32'h2468ACE0, 1'b0);
    endtask

    task automatic test_timeout();
        // successful read first so the abort visibly clears rdata
        @(negedge clk);
        en_t = 1'b1; addr = 32'h80; mask = 4'b0000;
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hCAFEF00D; rsp_err = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b0;
        n_checks++;
        if ({t_done, t_fault, t_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL t_read: dn=%b flt=%b rd=%h required dn=1 flt=0 rd=cafef00d", t_done, t_fault, t_rdata);
        end
        en_t = 1'b0;

        // write: handshake then no response -> 1 REQ + 3 WAIT cycles, rdata untouched
        @(negedge clk);
        en_t = 1'b1; mask = 4'b1111; wdata = 32'h01020304;
        @(negedge clk);
        req_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_ready = 1'b0;
            n_checks++;
            if ({t_stall, t_done, t_req_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL t_wait c=%0d: st=%b dn=%b v=%b required st=1 dn=0 v=0", c, t_stall, t_done, t_req_valid);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({t_done, t_fault, t_stall, t_rdata} !== {1'b1, 1'b1, 1'b0, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL t_wr_timeout: dn=%b flt=%b st=%b rd=%h required dn=1 flt=1 st=0 rd=cafef00d",
                     t_done, t_fault, t_stall, t_rdata);
        end
        en_t = 1'b0;

        // read: ready never comes -> valid for exactly 4 REQ cycles
        @(negedge clk);
        en_t = 1'b1; mask = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({t_req_valid, t_stall, t_done, t_rdata} !== {1'b1, 1'b1, 1'b0, 32'hCAFEF00D}) begin
                n_fail++;
                $display("FAIL t_req c=%0d: v=%b st=%b dn=%b rd=%h required v=1 st=1 dn=0 rd=cafef00d",
                         c, t_req_valid, t_stall, t_done, t_rdata);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({t_req_valid, t_done, t_fault, t_stall, t_rdata} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL t_rd_timeout: v=%b dn=%b flt=%b st=%b rd=%h required v=0 dn=1 flt=1 st=0 rd=0",
                     t_req_valid, t_done, t_fault, t_stall, t_rdata);
        end
        en_t = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h55AA55AA;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({t_done, t_req_valid, t_stall, t_rdata} !== 35'd0) begin
                n_fail++;
                $display("FAIL t_late_rsp c=%0d: dn=%b v=%b st=%b rd=%h required 0", c, t_done, t_req_valid, t_stall, t_rdata);
            end
        end
        rsp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_sb_steering();
        test_sh_backpressure();
        test_bus_error();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32im_dmem_ctrl.md
Name: rv32im_dmem_ctrl

Overview:
Data-memory bus controller directly downstream of the rv32im load/store unit. It accepts the LSU's word address, byte write mask, enable and store data, and issues one transaction per access on a valid/ready request channel with a separate response channel. It steers store data onto the correct byte lanes, returns the raw 32-bit read word for the LSU to extract, and stalls the pipeline until the access completes or times out.

Parameters:
DATA_W, 32, data bus width; only 32 is supported.
ADDR_W, 32, word-address width; matches the LSU word address output.
TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is aborted; legal range 1..255.

Ports:
clk_i  in  1  single clock; all state changes on the rising edge.
rst_ni  in  1  asynchronous, active-low reset.
enable_i  in  1  LSU access request, level-sensitive.
addr_i  in  ADDR_W  word address from the LSU.
wr_mask_i  in  4  byte write mask; 0000 means read.
wdata_i  in  DATA_W  store data, right-aligned.
rdata_o  out  DATA_W  registered raw read word returned to the LSU.
stall_o  out  1  freezes the pipeline while an access is in flight.
done_o  out  1  one-cycle completion pulse.
fault_o  out  1  one-cycle pulse together with done_o on a bus error or timeout.
req_valid_o  out  1  bus request valid.
req_ready_i  in  1  bus request accepted.
req_we_o  out  1  1 = write.
req_addr_o  out  ADDR_W  request word address.
req_be_o  out  4  request byte enables.
req_wdata_o  out  DATA_W  lane-steered write data.
rsp_valid_i  in  1  bus response valid.
rsp_rdata_i  in  DATA_W  read response data.
rsp_err_i  in  1  response error, qualified by rsp_valid_i.

Behaviour:
- Reset values: state IDLE. rdata_o=0. stall_o=0 (enable_i is forced low at the core while in reset). done_o, fault_o, req_valid_o, req_we_o all 0. req_addr_o, req_be_o, req_wdata_o all 0. Timeout counter 0.
- States:
  - IDLE: if enable_i=1, latch addr_i, wr_mask_i and steered wdata_i, clear the counter, and go to REQ. stall_o = enable_i (combinational) in IDLE.
  - REQ: req_valid_o=1. addr/we/be/wdata come from the latched registers and stay stable until req_ready_i=1. On req_valid_o && req_ready_i, go to WAIT.
  - WAIT: on rsp_valid_i, go to DONE. For a read, capture rsp_rdata_i into rdata_o. If rsp_err_i=1, flag a fault.
  - DONE: done_o=1, fault_o=flag, stall_o=0. Unconditionally go to IDLE next cycle. enable_i seen in DONE is the already-served access and is ignored.
- rsp_valid_i is ignored outside WAIT; a response in the same cycle as the request handshake is not legal.
- stall_o=1 in REQ and WAIT.
- req_we_o = (latched mask != 0).
- Lane steering, decided from the mask:
  - single-bit mask: replicate wdata[7:0] on all 4 lanes.
  - 0011 or 1100: replicate wdata[15:0] on both halves.
  - 1111 or any other mask: pass wdata unchanged.
  - req_be_o = the latched mask, or 1111 for reads.
- Timeout: the counter increments every cycle in REQ or WAIT. When it reaches TIMEOUT without completion, drop req_valid_o and go to DONE with fault set. A late response after a timeout is ignored.
- Faulted read: rdata_o is set to 0. Faulted write: no side effects at this block.
- rdata_o holds its value until the next successful read or a faulted read. Writes do not change it.
- Latency: zero-wait bus (ready in the REQ cycle, response the next cycle) gives IDLE→REQ→WAIT→DONE, i.e. stall_o is high for 3 cycles.
- Async reset asserted mid-access: req_valid_o drops immediately, the state returns to IDLE, and no done_o is produced.

Test Plan:
- Read, zero-wait: enable_i=1, addr_i=0x40, mask=0000; ready in REQ; response 0xDEADBEEF next cycle -> req_we_o=0, req_be_o=1111, stall_o high 3 cycles, done_o pulse, rdata_o=0xDEADBEEF, fault_o=0.
- SB steering: mask=0100, wdata=0x000000A5 -> req_wdata_o=0xA5A5A5A5, req_be_o=0100, req_we_o=1, rdata_o unchanged.
- SH with backpressure: mask=1100, wdata=0x00001234; ready held low 4 cycles -> req_valid_o, req_addr_o, req_wdata_o=0x12341234 stable for all 5 REQ cycles; done_o fires 2 cycles after the handshake.
- Bus error: read with rsp_err_i=1 and rsp_rdata_i=0x55 -> done_o=fault_o=1 in the same cycle, rdata_o=0.
- Timeout with TIMEOUT=4: ready never asserted -> req_valid_o drops after 4 REQ cycles, done_o=fault_o=1, then IDLE; a response injected later is ignored.
- Reset mid-WAIT: rst_ni low during WAIT -> req_valid_o=0, stall_o=0, rdata_o=0 immediately; after release, a new read completes normally.
